led_pwm_driver: RTL and testbench

//  Output stage between the LED register block and the board LED pins.

---
 rtl/led_pwm_driver_pkg.sv | 27 ++
 rtl/led_pwm_driver_if.sv | 18 +
 rtl/led_pwm_driver_blink_timer.sv | 40 ++++
 rtl/led_pwm_driver.sv | 114 +++++++++++
 tb/tb_led_pwm_driver.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_pwm_driver_pkg.sv
// ============================================================================
// Module : led_pwm_driver_pkg
// Brief  : Shared register addresses and defaults for the LED PWM output stage
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package led_pwm_driver_pkg;

  // Register map seen on the config bus (also used by the IO decoder)
  localparam logic [1:0] LED_PWM_ADDR_DUTY  = 2'b00;
  localparam logic [1:0] LED_PWM_ADDR_MASK  = 2'b01;
  localparam logic [1:0] LED_PWM_ADDR_BLINK = 2'b10;

  // Default PWM counter width; period is 2^CNT_W clocks
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    CFG_DUTY   = LED_PWM_ADDR_DUTY,
    CFG_MASK   = LED_PWM_ADDR_MASK,
    CFG_BLINK  = LED_PWM_ADDR_BLINK,
    CFG_UNUSED = 2'b11
  } cfg_addr_e;

endpackage

`default_nettype wire

// File: rtl/led_pwm_driver_if.sv
// ============================================================================
// Module : led_pwm_driver_if
// Brief  : Memory-mapped config bus (cs/write/addr/wdata) for the LED PWM stage
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface led_pwm_driver_if;
  logic        cfgcs;
  logic        cfgwrite;
  logic [1:0]  cfgaddr;
  logic [31:0] cfgwdata;

  modport master (output cfgcs, cfgwrite, cfgaddr, cfgwdata);
  modport slave  (input  cfgcs, cfgwrite, cfgaddr, cfgwdata);
endinterface

`default_nettype wire

// File: rtl/led_pwm_driver_blink_timer.sv
// ============================================================================
// Module : led_pwm_driver_blink_timer
// Brief  : Blink half-period counter and phase; restartable, disabled at half=0
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_pwm_driver_blink_timer #(
  parameter int BLINK_DIV_W = 24
) (
  input  wire logic                   clk,
  input  wire logic                   rst_n,
  input  wire logic                   restart,
  input  wire logic [BLINK_DIV_W-1:0] half,
  output logic                        phase
);

  localparam logic [BLINK_DIV_W-1:0] CNT_ONE = {{(BLINK_DIV_W-1){1'b0}}, 1'b1};

  logic [BLINK_DIV_W-1:0] blink_cnt;

  // Count 0..half-1 and toggle the phase on each rollover; restart or half=0 parks at phase 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (restart || (half == '0)) begin
      blink_cnt <= '0;
      phase     <= 1'b1;
    end else if (blink_cnt == (half - CNT_ONE)) begin
      blink_cnt <= '0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_pwm_driver.sv
// ============================================================================
// Module : led_pwm_driver
// Brief  : LED output stage: global brightness PWM with shadowed duty plus
//          per-bit blinking, two-stage registered datapath to the pins
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module led_pwm_driver
  import led_pwm_driver_pkg::*;
#(
  parameter int LED_N       = 16,
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int BLINK_DIV_W = 24
) (
  input  wire logic              led_clk,
  input  wire logic              ledrst_n,
  input  wire logic [LED_N-1:0]  led_in,
  led_pwm_driver_if.slave        cfg,
  output logic      [LED_N-1:0]  led_pwm,
  output logic                   pwm_sync
);

  localparam logic [CNT_W:0]   DUTY_FULL = {1'b1, {CNT_W{1'b0}}};
  localparam logic [CNT_W-1:0] PWM_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0]       pwm_cnt;
  logic [CNT_W:0]         duty_pend;
  logic [CNT_W:0]         duty_act;
  logic [LED_N-1:0]       blink_mask;
  logic [BLINK_DIV_W-1:0] blink_half;
  logic [LED_N-1:0]       led_q;
  logic                   blink_phase;

  logic                   cfg_we;
  logic                   blink_restart;
  logic                   pwm_wrap;
  logic                   pwm_on;
  logic [CNT_W:0]         duty_wr;
  logic [LED_N-1:0]       blink_gate;
  logic                   unused_wdata;

  assign cfg_we        = cfg.cfgcs & cfg.cfgwrite;
  assign blink_restart = cfg_we & (cfg.cfgaddr == CFG_BLINK);
  assign pwm_wrap      = &pwm_cnt;
  assign pwm_on        = ({1'b0, pwm_cnt} < duty_act);
  assign unused_wdata  = &{1'b0, cfg.cfgwdata[31:BLINK_DIV_W]};

  // Saturate the written duty to full-on
  always_comb begin
    duty_wr = cfg.cfgwdata[CNT_W:0];
    if (duty_wr > DUTY_FULL) begin
      duty_wr = DUTY_FULL;
    end
  end

  // Bits outside the blink mask always pass; masked bits follow the blink phase
  assign blink_gate = ~blink_mask | {LED_N{blink_phase}};

  // Config registers: written only on a selected write strobe
  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      duty_pend  <= DUTY_FULL;
      blink_mask <= '0;
      blink_half <= '0;
    end else if (cfg_we) begin
      case (cfg.cfgaddr)
        CFG_DUTY:  duty_pend  <= duty_wr;
        CFG_MASK:  blink_mask <= cfg.cfgwdata[LED_N-1:0];
        CFG_BLINK: blink_half <= cfg.cfgwdata[BLINK_DIV_W-1:0];
        default:   ;
      endcase
    end
  end

  // Free-running PWM counter; the active duty only changes at the period wrap
  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      pwm_cnt  <= '0;
      duty_act <= DUTY_FULL;
    end else begin
      pwm_cnt <= pwm_cnt + PWM_ONE;
      if (pwm_wrap) begin
        duty_act <= duty_pend;
      end
    end
  end

  // Two-stage output: capture the pattern, then gate it with PWM and blink
  always_ff @(posedge led_clk or negedge ledrst_n) begin
    if (!ledrst_n) begin
      led_q    <= '0;
      led_pwm  <= '0;
      pwm_sync <= 1'b0;
    end else begin
      led_q    <= led_in;
      led_pwm  <= led_q & {LED_N{pwm_on}} & blink_gate;
      pwm_sync <= (pwm_cnt == '0);
    end
  end

  led_pwm_driver_blink_timer #(
    .BLINK_DIV_W (BLINK_DIV_W)
  ) u_blink_timer (
    .clk     (led_clk),
    .rst_n   (ledrst_n),
    .restart (blink_restart),
    .half    (blink_half),
    .phase   (blink_phase)
  );

endmodule

`default_nettype wire

// File: tb/tb_led_pwm_driver.sv
// ============================================================================
// Module : tb_led_pwm_driver
// Brief  : Self-checking bench for led_pwm_driver against a timeline model
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_led_pwm_driver;

  logic        clk;
  logic        rst_n;
  logic [15:0] led_in;
  logic [15:0] led_pwm;
  logic        pwm_sync;

  led_pwm_driver_if cfg ();

  led_pwm_driver u_dut (
    .led_clk  (clk),
    .ledrst_n (rst_n),
    .led_in   (led_in),
    .cfg      (cfg.slave),
    .led_pwm  (led_pwm),
    .pwm_sync (pwm_sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: time since reset drives the PWM position, time since the
  // last blink write drives the blink phase, duty changes land on period edges.
  int          m_t;
  int          m_bstart;
  int          m_duty_pend;
  int          m_duty_act;
  int          m_half;
  logic [15:0] m_mask;
  logic [15:0] m_ledq;
  logic [15:0] exp_pwm;
  logic        exp_sync;

  always @(posedge clk or negedge rst_n) begin
    int pos;
    int wd;
    bit ph;
    if (!rst_n) begin
      m_t = 0; m_bstart = 0; m_duty_pend = 256; m_duty_act = 256;
      m_half = 0; m_mask = '0; m_ledq = '0; exp_pwm = '0; exp_sync = 1'b0;
    end else begin
      pos      = m_t % 256;
      ph       = (m_half == 0) ? 1'b1 : ((((m_t - m_bstart) / m_half) % 2) == 0);
      exp_sync = (pos == 0);
      exp_pwm  = (pos < m_duty_act) ? (m_ledq & (~m_mask | (ph ? 16'hFFFF : 16'h0000))) : 16'h0000;
      if (pos == 255) m_duty_act = m_duty_pend;
      if (cfg.cfgcs && cfg.cfgwrite) begin
        case (cfg.cfgaddr)
          2'b00: begin
            wd = int'(cfg.cfgwdata[8:0]);
            m_duty_pend = (wd > 256) ? 256 : wd;
          end
          2'b01: m_mask = cfg.cfgwdata[15:0];
          2'b10: begin
            m_half   = int'(cfg.cfgwdata[23:0]);
            m_bstart = m_t + 1;
          end
          default: ;
        endcase
      end
      m_ledq = led_in;
      m_t    = m_t + 1;
    end
  end

  task automatic cfg_write(input logic cs, input logic we, input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    cfg.cfgcs = cs; cfg.cfgwrite = we; cfg.cfgaddr = addr; cfg.cfgwdata = data;
    @(negedge clk);
    cfg.cfgcs = 1'b0; cfg.cfgwrite = 1'b0;
  endtask

  // Waits (bounded) for a sync pulse, then counts high cycles of one bit over a period
  task automatic measure_period(input int bit_i, output int highs, output bit ok);
    int n;
    highs = 0;
    ok    = 1'b0;
    for (n = 0; n < 600; n++) begin
      @(negedge clk);
      if (pwm_sync === 1'b1) begin ok = 1'b1; break; end
    end
    if (ok) begin
      for (int k = 0; k < 256; k++) begin
        if (led_pwm[bit_i] === 1'b1) highs++;
        @(negedge clk);
      end
    end
  endtask

  task automatic wait_pos(input int p);
    for (int n = 0; n < 300; n++) begin
      if ((m_t % 256) == p) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; led_in = '0;
    cfg.cfgcs = 1'b0; cfg.cfgwrite = 1'b0; cfg.cfgaddr = 2'b00; cfg.cfgwdata = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (led_pwm !== 16'h0000 || pwm_sync !== 1'b0) begin
      failures++;
      $display("FAIL reset_state led_pwm=%h pwm_sync=%b required 0000/0", led_pwm, pwm_sync);
    end
    rst_n = 1'b1;
    led_in = 16'hA5A5;
  endtask

  task automatic test_passthrough;
    int syncs = 0;
    int last  = -1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      checks++;
      if (led_pwm !== exp_pwm || pwm_sync !== exp_sync) begin
        failures++;
        $display("FAIL passthrough cyc=%0d led_pwm=%h sync=%b required %h/%b", c, led_pwm, pwm_sync, exp_pwm, exp_sync);
      end
      if (c >= 2) begin
        checks++;
        if (led_pwm !== 16'hA5A5) begin
          failures++;
          $display("FAIL full_on cyc=%0d led_pwm=%h required a5a5", c, led_pwm);
        end
      end
      if (pwm_sync === 1'b1) begin
        if (last >= 0) begin
          checks++;
          if (c - last != 256) begin
            failures++;
            $display("FAIL sync_interval got=%0d required 256", c - last);
          end
        end
        last = c; syncs++;
      end
    end
    checks++;
    if (syncs != 3) begin
      failures++;
      $display("FAIL sync_count got=%0d required 3", syncs);
    end
  endtask

  task automatic test_duty;
    int  highs;
    bit  ok;
    wait_pos(100);
    cfg_write(1'b1, 1'b1, 2'b00, 32'd64);
    // Remainder of this period still runs at full duty
    while ((m_t % 256) != 0) begin
      @(negedge clk);
      checks++;
      if (led_pwm[0] !== 1'b1) begin
        failures++;
        $display("FAIL duty_old_kept pos=%0d bit0=%b required 1", m_t % 256, led_pwm[0]);
      end
    end
    measure_period(0, highs, ok);
    checks++;
    if (!ok || highs != 64) begin
      failures++;
      $display("FAIL duty64_highs got=%0d ok=%0b required 64", highs, ok);
    end
    cfg_write(1'b1, 1'b1, 2'b00, 32'd0);
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      led_in = 16'($urandom);
      checks++;
      if (led_pwm !== exp_pwm || pwm_sync !== exp_sync) begin
        failures++;
        $display("FAIL duty0 cyc=%0d led_pwm=%h required %h", c, led_pwm, exp_pwm);
      end
    end
    checks++;
    if (led_pwm !== 16'h0000) begin
      failures++;
      $display("FAIL duty0_dark led_pwm=%h required 0000", led_pwm);
    end
    cfg_write(1'b1, 1'b1, 2'b00, 32'd300);
    led_in = 16'hFFFF;
    measure_period(7, highs, ok);
    measure_period(7, highs, ok);
    checks++;
    if (!ok || highs != 256) begin
      failures++;
      $display("FAIL duty300_saturate got=%0d ok=%0b required 256", highs, ok);
    end
  endtask

  task automatic test_blink;
    led_in = 16'hFFFF;
    cfg_write(1'b1, 1'b1, 2'b00, 32'd256);
    cfg_write(1'b1, 1'b1, 2'b01, 32'h0000_000F);
    cfg_write(1'b1, 1'b1, 2'b10, 32'd10);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if (led_pwm !== exp_pwm || pwm_sync !== exp_sync) begin
        failures++;
        $display("FAIL blink cyc=%0d led_pwm=%h required %h", c, led_pwm, exp_pwm);
      end
      checks++;
      if (led_pwm[15:4] !== 12'hFFF) begin
        failures++;
        $display("FAIL blink_unmasked cyc=%0d hi=%h required fff", c, led_pwm[15:4]);
      end
    end
    cfg_write(1'b1, 1'b1, 2'b10, 32'd0);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      checks++;
      if (led_pwm !== 16'hFFFF) begin
        failures++;
        $display("FAIL blink_off cyc=%0d led_pwm=%h required ffff", c, led_pwm);
      end
    end
  endtask

  task automatic test_ignored_and_wrap;
    int highs;
    bit ok;
    cfg_write(1'b1, 1'b1, 2'b11, 32'h0000_0000);
    cfg_write(1'b0, 1'b1, 2'b00, 32'd0);
    cfg_write(1'b0, 1'b1, 2'b01, 32'hFFFF);
    cfg_write(1'b1, 1'b0, 2'b10, 32'd3);
    cfg_write(1'b1, 1'b0, 2'b00, 32'd0);
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      checks++;
      if (led_pwm !== 16'hFFFF || led_pwm !== exp_pwm) begin
        failures++;
        $display("FAIL ignored_writes cyc=%0d led_pwm=%h required ffff", c, led_pwm);
      end
    end
    cfg_write(1'b1, 1'b1, 2'b00, 32'd200);
    measure_period(2, highs, ok);
    wait_pos(255);
    cfg.cfgcs = 1'b1; cfg.cfgwrite = 1'b1; cfg.cfgaddr = 2'b00; cfg.cfgwdata = 32'd50;
    @(negedge clk);
    cfg.cfgcs = 1'b0; cfg.cfgwrite = 1'b0;
    measure_period(2, highs, ok);
    checks++;
    if (!ok || highs != 200) begin
      failures++;
      $display("FAIL wrap_write_delayed got=%0d ok=%0b required 200", highs, ok);
    end
    measure_period(2, highs, ok);
    checks++;
    if (!ok || highs != 50) begin
      failures++;
      $display("FAIL wrap_write_applied got=%0d ok=%0b required 50", highs, ok);
    end
  endtask

  task automatic test_reset_mid;
    cfg_write(1'b1, 1'b1, 2'b00, 32'd32);
    cfg_write(1'b1, 1'b1, 2'b01, 32'h0000_00F0);
    cfg_write(1'b1, 1'b1, 2'b10, 32'd7);
    led_in = 16'hFFFF;
    repeat (300) @(negedge clk);
    wait_pos(10);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led_pwm !== 16'h0000 || pwm_sync !== 1'b0) begin
      failures++;
      $display("FAIL async_reset led_pwm=%h sync=%b required 0000/0", led_pwm, pwm_sync);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 600; c++) begin
      @(negedge clk);
      checks++;
      if (led_pwm !== exp_pwm || pwm_sync !== exp_sync) begin
        failures++;
        $display("FAIL after_reset cyc=%0d led_pwm=%h sync=%b required %h/%b", c, led_pwm, pwm_sync, exp_pwm, exp_sync);
      end
      if (c == 1) begin
        checks++;
        if (pwm_sync !== 1'b1) begin
          failures++;
          $display("FAIL restart_sync sync=%b required 1", pwm_sync);
        end
      end
      if (c >= 2) begin
        checks++;
        if (led_pwm !== 16'hFFFF) begin
          failures++;
          $display("FAIL restart_full_on cyc=%0d led_pwm=%h required ffff", c, led_pwm);
        end
      end
    end
  endtask

  task automatic test_random;
    logic [1:0] a;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      checks++;
      if (led_pwm !== exp_pwm || pwm_sync !== exp_sync) begin
        failures++;
        $display("FAIL random cyc=%0d led_pwm=%h sync=%b required %h/%b", c, led_pwm, pwm_sync, exp_pwm, exp_sync);
      end
      led_in = 16'($urandom);
      a = 2'($urandom_range(0, 3));
      cfg.cfgcs    = ($urandom_range(0, 15) == 0);
      cfg.cfgwrite = ($urandom_range(0, 3) != 0);
      cfg.cfgaddr  = a;
      cfg.cfgwdata = (a == 2'b00) ? 32'($urandom_range(0, 400)) :
                     (a == 2'b10) ? 32'($urandom_range(0, 12)) : $urandom;
    end
    cfg.cfgcs = 1'b0; cfg.cfgwrite = 1'b0;
  endtask

  initial begin
    test_reset;
    test_passthrough;
    test_duty;
    test_blink;
    test_ignored_and_wrap;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
